axis_network_data_upsizer: RTL
==============================

# axis_network_data_upsizer

Packs a 1-byte-wide AXI Stream into 64-bit NoC flits (HEADER, BODY, TAIL, HEADER_TAIL), embedding TID, TDEST, TLAST and padding in the flit fields the NoC-side downsizer decodes. It sits in the network interface injection path, between a byte-wide AXIS producer and the NoC router input port. It is the exact inverse of the downsizer: any packet sent through this block and then the downsizer is reproduced byte-for-byte.

## Interface
- AxisDataWidth, 8: TDATA width; only 8 supported.
- NocDataWidth, 64: flit width; only 64 supported.
- flitTypeSize, 2: flit type width.
- KeepEnable, 0: 1 = bytes with tkeep=0 are dropped; 0 = tkeep ignored.
- TIdWidth, 5: TID width, packed into a 5-bit field.
- TDestWidth, 11: TDEST width, packed into an 11-bit field.
- s_axis_aclk  in  1  single clock.
- s_axis_arstn  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  8  payload byte.
- s_axis_tvalid  in  1  byte valid.
- s_axis_tready  out  1  byte accepted when high with tvalid.
- s_axis_tlast  in  1  last byte of packet.
- s_axis_tkeep  in  1  byte qualifier (KeepEnable=1 only).
- s_axis_tid  in  TIdWidth  stream id, sampled on first beat.
- s_axis_tdest  in  TDestWidth  destination, sampled on first beat.
- network_flit_o  out  64  flit.
- network_flit_type_o  out  2  HEADER=00, BODY=01, TAIL=10, HEADER_TAIL=11.
- network_valid_o  out  1  flit valid.
- network_ready_i  in  1  router accepts flit.

## Operation
- Byte i of a flit occupies flit[8i+:8]; the first byte received goes in byte 0.
- HEADER and HEADER_TAIL flits:
  - bytes 0..3 carry payload.
  - [35:32] padding: one-hot at bit k when k<4 valid bytes; 0 when 4 bytes are valid.
  - [36] tlast.
  - [41:37] tid; [52:42] zero; [63:53] tdest.
- BODY flits: 8 payload bytes.
- TAIL flits:
  - bytes 0..6 carry payload.
  - [62:56] padding: one-hot at bit k when k<7 valid bytes; 0 when 7 bytes are valid.
  - [63] = 1.
- Unused payload bytes are zero.
- The empty TAIL flit is the constant 64'hFF00_0000_0000_0000.
- FSM states:
  - HDR: collect up to 4 bytes. tlast at count n≤4 → emit HEADER_TAIL (padding n, [36]=1), go to HDR. 4th byte without tlast → emit HEADER ([36]=0), go to BODY.
  - BODY: collect bytes. tlast at count k≤7 → emit TAIL with k bytes, go to HDR. 8th byte without tlast → emit BODY. 8th byte with tlast → emit BODY, go to ETAIL.
  - ETAIL: emit the empty TAIL, go to HDR; s_axis_tready=0 while in this state.
- KeepEnable=1:
  - A tkeep=0 beat is accepted but not stored and does not advance the count.
  - If such a beat carries tlast, the current flit closes with the bytes collected so far. This yields an empty HEADER_TAIL (padding bit 32) in HDR, or the empty TAIL in BODY.
- tid and tdest are latched on the first accepted beat of each packet.

## Timing
- The output is a single register stage: network_* change only when network_valid_o=0 or network_ready_i=1.
- Flit and type are stable while valid=1 and ready=0.
- Latency: the completing byte is accepted in cycle t → network_valid_o=1 in cycle t+1.
- s_axis_tready = (state≠ETAIL) & (!network_valid_o | network_ready_i).
- Simultaneous flit consumption and completing byte: the new flit loads the same cycle; no bubble.
- ETAIL emission waits for a free output register.
- Reset, asynchronous and effective mid-packet:
  - state=HDR, counters 0, network_valid_o=0, network_flit_o=0, network_flit_type_o=00, s_axis_tready=0 while reset is asserted.
  - A partial packet is discarded.
- Throughput with the router always ready: 1 byte/cycle; a BODY+empty-TAIL pair costs one input stall cycle.

## Structure
- Shared package noc_flit_pkg holds:
  - flit type codes;
  - field offsets and sizes (padding 32/4, 56/7; last 36, 63; tid 37/5; tdest 53/11);
  - the empty-TAIL constant.
- The downsizer uses the same package.
- No sub-module: FSM, byte shifter and output register stay in one module.

## Test plan
- 3-byte packet 0x11,0x22,0x33, tid=3, tdest=0x2A5 → one HEADER_TAIL, flit = 64'h54A0_0078_0033_2211.
- 4-byte packet 0x01..0x04 → HEADER_TAIL with padding 0, [36]=1, bytes 04030201.
- 4+8+5 = 17 bytes → HEADER, BODY (8 bytes), TAIL with padding bit 61 (bit 5 of the field) set and bit 63 set.
- 12 bytes → HEADER, BODY, then 64'hFF00_0000_0000_0000 TAIL. s_axis_tready=0 for exactly the ETAIL cycle.
- network_ready_i held low for 10 cycles mid-packet → flit held stable, s_axis_tready=0 once a flit is pending; no byte is lost or duplicated.
- KeepEnable=1, beats tkeep 1,0,1 then tlast with tkeep=0 → HEADER_TAIL with 2 bytes (padding bit 34). Reset asserted mid-BODY → valid=0 immediately; the next packet starts in HDR.

Source files
------------

// File: rtl/noc_flit_pkg.sv
// Shared NoC flit definitions used by the AXIS upsizer and the NoC-side downsizer.
// Holds the flit type codes, the bit positions of the control fields packed into
// HEADER/TAIL flits, the empty-TAIL constant and the padding encoders.
package noc_flit_pkg;

    typedef enum logic [1:0] {
        FlitHeader     = 2'b00,
        FlitBody       = 2'b01,
        FlitTail       = 2'b10,
        FlitHeaderTail = 2'b11
    } flit_type_e;

    // HEADER / HEADER_TAIL field layout
    localparam int unsigned HdrPayloadBytes = 4;
    localparam int unsigned HdrPadOffset    = 32;
    localparam int unsigned HdrPadSize      = 4;
    localparam int unsigned HdrLastBit      = 36;
    localparam int unsigned TidOffset       = 37;
    localparam int unsigned TidSize         = 5;
    localparam int unsigned TdestOffset     = 53;
    localparam int unsigned TdestSize       = 11;

    // TAIL field layout
    localparam int unsigned TailPayloadBytes = 7;
    localparam int unsigned TailPadOffset    = 56;
    localparam int unsigned TailPadSize      = 7;
    localparam int unsigned TailLastBit      = 63;

    localparam int unsigned BodyPayloadBytes = 8;

    // A TAIL carrying no payload; the downsizer recognises it by this exact value.
    localparam logic [63:0] EmptyTail = 64'hFF00_0000_0000_0000;

    // One-hot at the count of valid bytes; all-zero when the header is full.
    function automatic logic [HdrPadSize-1:0] hdr_pad(input logic [3:0] n);
        hdr_pad = '0;
        if (n < 4'(HdrPayloadBytes)) begin
            hdr_pad[n[1:0]] = 1'b1;
        end
    endfunction

    // One-hot at the count of valid bytes; all-zero when the tail is full.
    function automatic logic [TailPadSize-1:0] tail_pad(input logic [3:0] n);
        tail_pad = '0;
        if (n < 4'(TailPayloadBytes)) begin
            tail_pad[n[2:0]] = 1'b1;
        end
    endfunction

endpackage

// File: rtl/axis_network_data_upsizer.sv
// Packs a byte-wide AXI Stream into 64-bit NoC flits (HEADER, BODY, TAIL,
// HEADER_TAIL) for the network interface injection path.
// Ports:
//   s_axis_aclk / s_axis_arstn      : clock, asynchronous active-low reset
//   s_axis_t{data,valid,ready,last,keep,id,dest} : byte-wide AXIS slave
//   network_flit_o / _type_o / _valid_o, network_ready_i : registered flit output
module axis_network_data_upsizer
    import noc_flit_pkg::*;
#(
    parameter int unsigned AxisDataWidth = 8,
    parameter int unsigned NocDataWidth  = 64,
    parameter int unsigned flitTypeSize  = 2,
    parameter int unsigned KeepEnable    = 0,
    parameter int unsigned TIdWidth      = 5,
    parameter int unsigned TDestWidth    = 11
) (
    input  logic                     s_axis_aclk,
    input  logic                     s_axis_arstn,
    input  logic [AxisDataWidth-1:0] s_axis_tdata,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic                     s_axis_tlast,
    input  logic                     s_axis_tkeep,
    input  logic [TIdWidth-1:0]      s_axis_tid,
    input  logic [TDestWidth-1:0]    s_axis_tdest,
    output logic [NocDataWidth-1:0]  network_flit_o,
    output logic [flitTypeSize-1:0]  network_flit_type_o,
    output logic                     network_valid_o,
    input  logic                     network_ready_i
);

    typedef enum logic [1:0] {StHdr, StBody, StEtail} state_e;

    state_e                    r_state, w_state_next;
    logic [3:0]                r_cnt, w_cnt_fill, w_cnt_d;
    logic [NocDataWidth-1:0]   r_buf, w_buf_fill, w_buf_d;
    logic                      r_in_pkt;
    logic [TIdWidth-1:0]       r_tid, w_tid;
    logic [TDestWidth-1:0]     r_tdest, w_tdest;
    logic [NocDataWidth-1:0]   r_flit, w_flit, w_hdr, w_tail;
    logic [flitTypeSize-1:0]   r_type, w_type;
    logic                      r_valid, w_emit;
    logic                      w_out_free, w_ready, w_accept, w_keep, w_store;

    assign w_out_free = !r_valid || network_ready_i;
    // Gated by the reset input so tready stays low while reset is held.
    assign w_ready    = s_axis_arstn && (r_state != StEtail) && w_out_free;
    assign w_accept   = s_axis_tvalid && w_ready;
    assign w_keep     = (KeepEnable != 0) ? s_axis_tkeep : 1'b1;
    assign w_store    = w_accept && w_keep;

    // The first accepted beat of a packet supplies tid/tdest directly.
    assign w_tid      = r_in_pkt ? r_tid : s_axis_tid;
    assign w_tdest    = r_in_pkt ? r_tdest : s_axis_tdest;

    // Buffer and count as they would be with the current beat included.
    always_comb begin
        w_buf_fill = r_buf;
        w_cnt_fill = r_cnt;
        if (w_store) begin
            for (int i = 0; i < 8; i++) begin
                if (r_cnt == 4'(i)) begin
                    w_buf_fill[8*i +: 8] = s_axis_tdata;
                end
            end
            w_cnt_fill = r_cnt + 4'd1;
        end
    end

    always_comb begin
        w_hdr                                = '0;
        w_hdr[8*HdrPayloadBytes-1:0]         = w_buf_fill[8*HdrPayloadBytes-1:0];
        w_hdr[HdrPadOffset +: HdrPadSize]    = hdr_pad(w_cnt_fill);
        w_hdr[HdrLastBit]                    = s_axis_tlast;
        w_hdr[TidOffset +: TidSize]          = w_tid;
        w_hdr[TdestOffset +: TdestSize]      = w_tdest;

        w_tail                               = w_buf_fill;
        w_tail[TailPadOffset +: TailPadSize] = tail_pad(w_cnt_fill);
        w_tail[TailLastBit]                  = 1'b1;
    end

    always_comb begin
        w_state_next = r_state;
        w_emit       = 1'b0;
        w_flit       = '0;
        w_type       = FlitHeader;
        w_buf_d      = w_buf_fill;
        w_cnt_d      = w_cnt_fill;

        unique case (r_state)
            StHdr: begin
                if (w_accept) begin
                    if (s_axis_tlast) begin
                        w_emit = 1'b1;
                        w_flit = w_hdr;
                        w_type = FlitHeaderTail;
                    end else if (w_cnt_fill == 4'(HdrPayloadBytes)) begin
                        w_emit       = 1'b1;
                        w_flit       = w_hdr;
                        w_type       = FlitHeader;
                        w_state_next = StBody;
                    end
                end
            end
            StBody: begin
                if (w_accept) begin
                    if (w_cnt_fill == 4'(BodyPayloadBytes)) begin
                        // A full BODY cannot carry the end marker; follow with an empty TAIL.
                        w_emit       = 1'b1;
                        w_flit       = w_buf_fill;
                        w_type       = FlitBody;
                        w_state_next = s_axis_tlast ? StEtail : StBody;
                    end else if (s_axis_tlast) begin
                        w_emit       = 1'b1;
                        w_flit       = (w_cnt_fill == 4'd0) ? EmptyTail : w_tail;
                        w_type       = FlitTail;
                        w_state_next = StHdr;
                    end
                end
            end
            StEtail: begin
                if (w_out_free) begin
                    w_emit       = 1'b1;
                    w_flit       = EmptyTail;
                    w_type       = FlitTail;
                    w_state_next = StHdr;
                end
            end
            default: w_state_next = StHdr;
        endcase

        if (w_emit) begin
            w_buf_d = '0;
            w_cnt_d = '0;
        end
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_arstn) begin
        if (!s_axis_arstn) begin
            r_state  <= StHdr;
            r_cnt    <= '0;
            r_buf    <= '0;
            r_in_pkt <= 1'b0;
            r_tid    <= '0;
            r_tdest  <= '0;
            r_flit   <= '0;
            r_type   <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_d;
            r_buf   <= w_buf_d;
            if (w_accept) begin
                r_in_pkt <= !s_axis_tlast;
                if (!r_in_pkt) begin
                    r_tid   <= s_axis_tid;
                    r_tdest <= s_axis_tdest;
                end
            end
            if (w_emit) begin
                r_flit  <= w_flit;
                r_type  <= w_type;
                r_valid <= 1'b1;
            end else if (network_ready_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign s_axis_tready       = w_ready;
    assign network_flit_o      = r_flit;
    assign network_flit_type_o = r_type;
    assign network_valid_o     = r_valid;

endmodule
